// File: rtl/register_bank.sv
// Parametrised register bank: one-hot/multi-hot write from the ALU bus, two
// registered read ports with write-first bypass, and a sequenced clear engine.
module register_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DEPTH-1:0]       reg_en,
  input  logic [WIDTH-1:0]       ALU_result,
  output logic                   wr_ready,
  output logic                   multi_hot,
  input  logic [AW-1:0]          rd_addr_a,
  input  logic [AW-1:0]          rd_addr_b,
  output logic [WIDTH-1:0]       rd_data_a,
  output logic [WIDTH-1:0]       rd_data_b,
  output logic [DEPTH*WIDTH-1:0] q_flat,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   clr_done
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    counter;
  logic [WIDTH-1:0] regs     [DEPTH];
  logic [WIDTH-1:0] reg_next [DEPTH];
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_b;
  logic             wr_accept;
  logic             clr_last;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_start) state_next = CLEAR;
      CLEAR:   if (clr_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state == CLEAR);
    wr_ready = (state == IDLE);
  end

  assign clr_last  = clr_busy && (counter == AW'(DEPTH - 1));
  assign wr_accept = wr_ready && (|reg_en);

  // Next-state of every register; the read ports index this array so that a
  // same-edge write or clear is visible in rd_data without extra muxing.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      reg_next[i] = regs[i];
      if (wr_accept && reg_en[i])
        reg_next[i] = ALU_result;
      else if (clr_busy && (counter == AW'(i)))
        reg_next[i] = '0;
    end
  end

  // Addresses at or beyond DEPTH match no entry and read back as zero.
  always_comb begin
    rd_next_a = '0;
    rd_next_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == AW'(i)) rd_next_a = reg_next[i];
      if (rd_addr_b == AW'(i)) rd_next_b = reg_next[i];
    end
  end

  always_comb begin
    q_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      q_flat[i*WIDTH +: WIDTH] = regs[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      counter   <= '0;
      clr_done  <= 1'b0;
      multi_hot <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      regs      <= reg_next;
      counter   <= clr_busy ? counter + 1'b1 : '0;
      clr_done  <= clr_last;
      rd_data_a <= rd_next_a;
      rd_data_b <= rd_next_b;
      if (wr_accept)
        multi_hot <= ((reg_en & (reg_en - 1'b1)) != '0);
    end
  end

endmodule
